// File: rtl/mmu_client.sv
// mmu_client: host-side requester for mmu_top. Hands out request IDs from a
// private pool, submits alloc/free requests, arbitrates the two MMU response
// FIFOs into a single completion register and flags unmatched responses.
module mmu_client #(
  parameter int ID_W  = 4,
  parameter int CNT_W = 4,
  parameter int IDX_W = 12,
  parameter int RSN_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_free,
  input  logic [CNT_W-1:0]  cmd_page_count,
  input  logic [IDX_W-1:0]  cmd_page_idx,
  output logic              alloc_req_submit,
  output logic              free_req_submit,
  output logic [ID_W-1:0]   req_id,
  output logic [CNT_W-1:0]  req_page_count,
  output logic [IDX_W-1:0]  req_page_idx,
  input  logic              alloc_req_fifo_full,
  input  logic              free_req_fifo_full,
  input  logic              alloc_rsp_fifo_not_empty,
  input  logic              free_rsp_fifo_not_empty,
  input  logic [ID_W-1:0]   alloc_rsp_id,
  input  logic [IDX_W-1:0]  alloc_rsp_page_idx,
  input  logic              alloc_rsp_fail,
  input  logic [RSN_W-1:0]  alloc_rsp_fail_reason,
  input  logic [ID_W-1:0]   free_rsp_id,
  input  logic              free_rsp_fail,
  input  logic [RSN_W-1:0]  free_rsp_fail_reason,
  output logic              alloc_rsp_pop,
  output logic              free_rsp_pop,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_is_free,
  output logic [ID_W-1:0]   done_id,
  output logic [IDX_W-1:0]  done_page_idx,
  output logic              done_fail,
  output logic [RSN_W-1:0]  done_reason,
  output logic [ID_W:0]     outstanding,
  output logic              err_unexpected
);

  localparam int N = 1 << ID_W;

  // busy: ID in flight; kind: 1 when the in-flight request is a free
  logic [N-1:0]    busy;
  logic [N-1:0]    kind;
  logic [ID_W-1:0] free_id;
  logic            any_free;
  logic            accept;
  logic            can_load;
  logic            a_cand;
  logic            f_cand;
  logic            grant_alloc;
  logic            grant_free;
  logic            grant;
  logic [ID_W-1:0] g_id;
  logic            match;
  logic            rel_ok;
  logic            rr_ptr;   // 0 = alloc has priority on a tie

  // Lowest-numbered idle ID (scan from the top so the lowest wins)
  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_id  = ID_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign cmd_ready        = any_free & ~(cmd_is_free ? free_req_fifo_full : alloc_req_fifo_full);
  assign accept           = cmd_valid & cmd_ready;
  assign alloc_req_submit = accept & ~cmd_is_free;
  assign free_req_submit  = accept & cmd_is_free;
  assign req_id           = free_id;
  assign req_page_count   = cmd_page_count;
  assign req_page_idx     = cmd_page_idx;

  // Pops only happen when the completion register can take the response
  assign can_load    = ~done_valid | done_ready;
  assign a_cand      = alloc_rsp_fifo_not_empty & can_load;
  assign f_cand      = free_rsp_fifo_not_empty & can_load;
  assign grant_alloc = a_cand & (~f_cand | ~rr_ptr);
  assign grant_free  = f_cand & (~a_cand | rr_ptr);
  assign grant       = grant_alloc | grant_free;
  assign g_id        = grant_free ? free_rsp_id : alloc_rsp_id;
  assign match       = busy[g_id] & (kind[g_id] == grant_free);
  assign rel_ok      = grant & match;

  assign alloc_rsp_pop = grant_alloc;
  assign free_rsp_pop  = grant_free;

  // Pool bitmaps: the accepted ID is never busy, the released one always is,
  // so the set and clear never target the same bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      kind <= '0;
    end else begin
      if (accept) begin
        busy[free_id] <= 1'b1;
        kind[free_id] <= cmd_is_free;
      end
      if (rel_ok) begin
        busy[g_id] <= 1'b0;
      end
    end
  end

  // Completion register, loaded from the granted response head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid    <= 1'b0;
      done_is_free  <= 1'b0;
      done_id       <= '0;
      done_page_idx <= '0;
      done_fail     <= 1'b0;
      done_reason   <= '0;
    end else if (grant) begin
      done_valid    <= 1'b1;
      done_is_free  <= grant_free;
      done_id       <= g_id;
      done_page_idx <= grant_free ? '0 : alloc_rsp_page_idx;
      done_fail     <= grant_free ? free_rsp_fail : alloc_rsp_fail;
      done_reason   <= grant_free ? free_rsp_fail_reason : alloc_rsp_fail_reason;
    end else if (done_ready) begin
      done_valid    <= 1'b0;
    end
  end

  // Arbiter pointer flips after every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // Outstanding count and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case ({accept, rel_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (grant && !match) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmu_client.sv
// tb_mmu_client: directed table-driven bench for mmu_client plus hand-written
// sequences for pool exhaustion, arbitration, backpressure, bad responses and reset.
module tb_mmu_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_is_free;
  logic [3:0]  cmd_page_count;
  logic [11:0] cmd_page_idx;
  logic        alloc_req_submit, free_req_submit;
  logic [3:0]  req_id, req_page_count;
  logic [11:0] req_page_idx;
  logic        alloc_req_fifo_full, free_req_fifo_full;
  logic        alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty;
  logic [3:0]  alloc_rsp_id, free_rsp_id;
  logic [11:0] alloc_rsp_page_idx;
  logic        alloc_rsp_fail, free_rsp_fail;
  logic [1:0]  alloc_rsp_fail_reason, free_rsp_fail_reason;
  logic        alloc_rsp_pop, free_rsp_pop;
  logic        done_valid, done_ready, done_is_free, done_fail;
  logic [3:0]  done_id;
  logic [11:0] done_page_idx;
  logic [1:0]  done_reason;
  logic [4:0]  outstanding;
  logic        err_unexpected;

  int pass_cnt = 0;
  int total_cnt = 0;

  mmu_client dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_free(cmd_is_free),
    .cmd_page_count(cmd_page_count), .cmd_page_idx(cmd_page_idx),
    .alloc_req_submit(alloc_req_submit), .free_req_submit(free_req_submit),
    .req_id(req_id), .req_page_count(req_page_count), .req_page_idx(req_page_idx),
    .alloc_req_fifo_full(alloc_req_fifo_full), .free_req_fifo_full(free_req_fifo_full),
    .alloc_rsp_fifo_not_empty(alloc_rsp_fifo_not_empty),
    .free_rsp_fifo_not_empty(free_rsp_fifo_not_empty),
    .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
    .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
    .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
    .free_rsp_fail_reason(free_rsp_fail_reason),
    .alloc_rsp_pop(alloc_rsp_pop), .free_rsp_pop(free_rsp_pop),
    .done_valid(done_valid), .done_ready(done_ready), .done_is_free(done_is_free),
    .done_id(done_id), .done_page_idx(done_page_idx), .done_fail(done_fail),
    .done_reason(done_reason), .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic        ane;
    logic [3:0]  rid;
    logic [11:0] ridx;
    logic        e_ready;
    logic        e_asub;
    logic [3:0]  e_reqid;
    logic        e_apop;
    logic        e_dv;
    logic [3:0]  e_did;
    logic [11:0] e_didx;
    logic [4:0]  e_out;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_is_free = 0; cmd_page_count = 4'd1; cmd_page_idx = 0;
    alloc_req_fifo_full = 0; free_req_fifo_full = 0;
    alloc_rsp_fifo_not_empty = 0; free_rsp_fifo_not_empty = 0;
    alloc_rsp_id = 0; free_rsp_id = 0; alloc_rsp_page_idx = 0;
    alloc_rsp_fail = 0; free_rsp_fail = 0;
    alloc_rsp_fail_reason = 0; free_rsp_fail_reason = 0;
    done_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    edge1();
    rst = 0;
  endtask

  task automatic issue(input int n, input int first_free);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1;
      cmd_is_free = (i >= first_free);
      edge1();
    end
    cmd_valid = 0;
    cmd_is_free = 0;
  endtask

  initial begin
    // ---------- reset state ----------
    idle_inputs();
    rst = 1;
    #1;
    chk("rst_done_valid", done_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexpected, 0);
    edge1();
    rst = 0;
    $display("reset: done_valid=%0d outstanding=%0d err=%0d", done_valid, outstanding, err_unexpected);

    // ---------- table: ten allocs then ten in-order responses ----------
    for (int i = 0; i < 10; i++) begin
      vt[i].cv = 1; vt[i].ane = 0; vt[i].rid = 0; vt[i].ridx = 0;
      vt[i].e_ready = 1; vt[i].e_asub = 1; vt[i].e_reqid = 4'(i); vt[i].e_apop = 0;
      vt[i].e_dv = 0; vt[i].e_did = 0; vt[i].e_didx = 0; vt[i].e_out = 5'(i + 1);
    end
    for (int j = 0; j < 10; j++) begin
      vt[10+j].cv = 0; vt[10+j].ane = 1; vt[10+j].rid = 4'(j); vt[10+j].ridx = 12'(100 + j);
      vt[10+j].e_ready = 1; vt[10+j].e_asub = 0;
      vt[10+j].e_reqid = (j == 0) ? 4'd10 : 4'd0;
      vt[10+j].e_apop = 1; vt[10+j].e_dv = 1; vt[10+j].e_did = 4'(j);
      vt[10+j].e_didx = 12'(100 + j); vt[10+j].e_out = 5'(9 - j);
    end
    vt[20].cv = 0; vt[20].ane = 0; vt[20].rid = 0; vt[20].ridx = 0;
    vt[20].e_ready = 1; vt[20].e_asub = 0; vt[20].e_reqid = 0; vt[20].e_apop = 0;
    vt[20].e_dv = 0; vt[20].e_did = 4'd9; vt[20].e_didx = 12'd109; vt[20].e_out = 0;

    for (int i = 0; i < 21; i++) begin
      cmd_valid = vt[i].cv;
      alloc_rsp_fifo_not_empty = vt[i].ane;
      alloc_rsp_id = vt[i].rid;
      alloc_rsp_page_idx = vt[i].ridx;
      #1;
      chk("tbl_cmd_ready", cmd_ready, vt[i].e_ready);
      chk("tbl_alloc_submit", alloc_req_submit, vt[i].e_asub);
      chk("tbl_free_submit", free_req_submit, 0);
      chk("tbl_req_id", req_id, vt[i].e_reqid);
      chk("tbl_alloc_pop", alloc_rsp_pop, vt[i].e_apop);
      chk("tbl_free_pop", free_rsp_pop, 0);
      edge1();
      chk("tbl_done_valid", done_valid, vt[i].e_dv);
      chk("tbl_done_id", done_id, vt[i].e_did);
      chk("tbl_done_idx", done_page_idx, vt[i].e_didx);
      chk("tbl_done_fail", done_fail, 0);
      chk("tbl_outstanding", outstanding, vt[i].e_out);
      $display("vec %0d: req_id=%0d pop=%0d done_id=%0d outstanding=%0d",
               i, req_id, alloc_rsp_pop, done_id, outstanding);
    end
    idle_inputs();

    // ---------- pool exhaustion and ID reuse ----------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cmd_valid = 1;
      #1;
      chk("pool_req_id", req_id, i);
      edge1();
    end
    chk("pool_outstanding16", outstanding, 16);
    #1;
    chk("pool_full_ready", cmd_ready, 0);
    chk("pool_full_nosubmit", alloc_req_submit, 0);
    alloc_rsp_fifo_not_empty = 1; alloc_rsp_id = 4'd5;
    #1;
    chk("pool_pop5", alloc_rsp_pop, 1);
    chk("pool_ready_prerelease", cmd_ready, 0);
    edge1();
    alloc_rsp_fifo_not_empty = 0;
    #1;
    chk("pool_reuse_ready", cmd_ready, 1);
    chk("pool_reuse_id", req_id, 5);
    chk("pool_reuse_submit", alloc_req_submit, 1);
    chk("pool_out15", outstanding, 15);
    edge1();
    cmd_valid = 0;
    chk("pool_out16_again", outstanding, 16);
    chk("pool_done_drained", done_valid, 0);
    $display("pool: reuse id=5 outstanding=%0d", outstanding);

    // ---------- round-robin arbitration and stall ----------
    do_reset();
    issue(4, 2);   // ids 0,1 alloc; ids 2,3 free
    alloc_rsp_fifo_not_empty = 1; free_rsp_fifo_not_empty = 1;
    alloc_rsp_id = 0; free_rsp_id = 2; alloc_rsp_page_idx = 12'h55;
    #1;
    chk("rr1_apop", alloc_rsp_pop, 1);
    chk("rr1_fpop", free_rsp_pop, 0);
    edge1();
    chk("rr1_done_id", done_id, 0);
    chk("rr1_done_type", done_is_free, 0);
    chk("rr1_done_idx", done_page_idx, 12'h55);
    alloc_rsp_id = 1;
    #1;
    chk("rr2_apop", alloc_rsp_pop, 0);
    chk("rr2_fpop", free_rsp_pop, 1);
    edge1();
    chk("rr2_done_id", done_id, 2);
    chk("rr2_done_type", done_is_free, 1);
    chk("rr2_done_idx", done_page_idx, 0);
    free_rsp_id = 3;
    #1;
    chk("rr3_apop", alloc_rsp_pop, 1);
    edge1();
    chk("rr3_done_id", done_id, 1);
    done_ready = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_apop", alloc_rsp_pop, 0);
      chk("stall_fpop", free_rsp_pop, 0);
      edge1();
      chk("stall_done_valid", done_valid, 1);
      chk("stall_done_id", done_id, 1);
    end
    done_ready = 1;
    #1;
    chk("rr4_fpop", free_rsp_pop, 1);
    chk("rr4_apop", alloc_rsp_pop, 0);
    edge1();
    alloc_rsp_fifo_not_empty = 0; free_rsp_fifo_not_empty = 0;
    chk("rr4_done_id", done_id, 3);
    chk("rr_err", err_unexpected, 0);
    chk("rr_outstanding", outstanding, 0);
    $display("arb: final done_id=%0d outstanding=%0d", done_id, outstanding);

    // ---------- free request under backpressure ----------
    do_reset();
    cmd_valid = 1; cmd_is_free = 1; cmd_page_idx = 12'd8; free_req_fifo_full = 1;
    #1;
    chk("bp_ready", cmd_ready, 0);
    chk("bp_fsub", free_req_submit, 0);
    chk("bp_idx_pass", req_page_idx, 8);
    edge1();
    chk("bp_out0", outstanding, 0);
    free_req_fifo_full = 0; alloc_req_fifo_full = 1;
    #1;
    chk("bp_release_ready", cmd_ready, 1);
    chk("bp_release_fsub", free_req_submit, 1);
    chk("bp_release_asub", alloc_req_submit, 0);
    edge1();
    cmd_valid = 0; alloc_req_fifo_full = 0;
    chk("bp_out1", outstanding, 1);
    $display("backpressure: outstanding=%0d", outstanding);

    // ---------- wrong-type response ----------
    do_reset();
    issue(4, 4);   // ids 0..3 alloc
    free_rsp_fifo_not_empty = 1; free_rsp_id = 4'd3;
    #1;
    chk("bad_fpop", free_rsp_pop, 1);
    edge1();
    free_rsp_fifo_not_empty = 0;
    chk("bad_err", err_unexpected, 1);
    chk("bad_done_valid", done_valid, 1);
    chk("bad_done_id", done_id, 3);
    chk("bad_done_type", done_is_free, 1);
    chk("bad_out", outstanding, 4);
    cmd_valid = 1;
    #1;
    chk("bad_id3_busy", req_id, 4);
    edge1();
    cmd_valid = 0;
    chk("bad_out5", outstanding, 5);
    $display("unexpected: err=%0d done_id=%0d outstanding=%0d", err_unexpected, done_id, outstanding);

    // ---------- reset mid-operation ----------
    rst = 1;
    #1;
    chk("mid_rst_done_valid", done_valid, 0);
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_err", err_unexpected, 0);
    chk("mid_rst_done_id", done_id, 0);
    chk("mid_rst_done_type", done_is_free, 0);
    edge1();
    rst = 0;
    cmd_valid = 1;
    #1;
    chk("post_rst_id", req_id, 0);
    chk("post_rst_submit", alloc_req_submit, 1);
    edge1();
    cmd_valid = 0;
    alloc_rsp_fifo_not_empty = 1; alloc_rsp_id = 4'd2;
    edge1();
    alloc_rsp_fifo_not_empty = 0;
    chk("stale_err", err_unexpected, 1);
    chk("stale_out", outstanding, 1);
    $display("reset-mid: err=%0d outstanding=%0d", err_unexpected, outstanding);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
